// File: rtl/s_stream_in_fifo.sv
// Streaming input buffer feeding a PE neighbour-operand port: accepts a programmed
// number of words over valid/ready, buffers them, and pops only when the array advances.
module s_stream_in_fifo #(
    parameter int N_BITS = 32,
    parameter int DEPTH  = 4,
    parameter int CNT_W  = 16
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     start_i,
    input  logic [CNT_W-1:0]         len_i,
    input  logic                     flush_i,
    input  logic [N_BITS-1:0]        s_data_i,
    input  logic                     s_valid_i,
    output logic                     s_ready_o,
    input  logic                     pea_ready_i,
    output logic [N_BITS-1:0]        op_o,
    output logic                     op_valid_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     busy_o,
    output logic                     done_o,
    output logic [1:0]               state_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    // Handshakes: a word moves on the source side when s_valid_i && s_ready_o at a
    // rising edge; the head moves to the PE when op_valid_o && pea_ready_i at a rising
    // edge. Neither ready depends combinationally on the opposite side's valid.

    state_t              state_q, state_d;
    logic [PW-1:0]       wr_ptr_q, rd_ptr_q, count;
    logic [CNT_W-1:0]    len_q, acc_cnt_q;
    logic [N_BITS-1:0]   mem_q [DEPTH];
    logic                done_q, done_d;
    logic                full, empty, push, pop;

    assign count = wr_ptr_q - rd_ptr_q;
    assign full  = (count == PW'(DEPTH));
    assign empty = (wr_ptr_q == rd_ptr_q);

    // Full wins over a same-cycle pop: no push-through into a full buffer.
    assign s_ready_o  = (state_q == RUN) && !full && (acc_cnt_q != len_q);
    assign push       = s_valid_i && s_ready_o;
    assign op_valid_o = !empty;
    assign pop        = op_valid_o && pea_ready_i;
    assign op_o       = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];

    assign count_o = count;
    assign busy_o  = (state_q != IDLE);
    assign done_o  = done_q;
    assign state_o = state_q;

    always_comb begin
        state_d = state_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    if (len_i == '0) done_d = 1'b1;
                    else             state_d = RUN;
                end
            end
            RUN: begin
                if (push && (acc_cnt_q + CNT_W'(1) == len_q)) state_d = DRAIN;
            end
            DRAIN: begin
                if (empty || (pop && count == PW'(1))) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            done_q    <= 1'b0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            len_q     <= '0;
            acc_cnt_q <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (flush_i) begin
            state_q   <= IDLE;
            done_q    <= 1'b0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            acc_cnt_q <= '0;
        end else begin
            state_q <= state_d;
            done_q  <= done_d;
            if (state_q == IDLE && start_i && len_i != '0) begin
                len_q     <= len_i;
                acc_cnt_q <= '0;
            end
            if (push) begin
                mem_q[wr_ptr_q[AW-1:0]] <= s_data_i;
                wr_ptr_q                <= wr_ptr_q + PW'(1);
                acc_cnt_q               <= acc_cnt_q + CNT_W'(1);
            end
            if (pop) rd_ptr_q <= rd_ptr_q + PW'(1);
        end
    end
endmodule

// File: tb/tb_s_stream_in_fifo.sv
// Bench for s_stream_in_fifo: queue-based transfer model, one task per scenario.
module tb_s_stream_in_fifo;
    localparam int N_BITS = 32;
    localparam int DEPTH  = 4;
    localparam int CNT_W  = 16;
    localparam int PW     = $clog2(DEPTH) + 1;
    localparam int VW     = 4 + PW + N_BITS;

    logic              clk = 1'b0;
    logic              rst_i = 1'b1;
    logic              start_i = 1'b0;
    logic [CNT_W-1:0]  len_i = '0;
    logic              flush_i = 1'b0;
    logic [N_BITS-1:0] s_data_i = '0;
    logic              s_valid_i = 1'b0;
    logic              pea_ready_i = 1'b0;
    logic              s_ready_o, op_valid_o, busy_o, done_o;
    logic [N_BITS-1:0] op_o;
    logic [PW-1:0]     count_o;
    logic [1:0]        dbg_state;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    s_stream_in_fifo #(.N_BITS(N_BITS), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .len_i(len_i), .flush_i(flush_i),
        .s_data_i(s_data_i), .s_valid_i(s_valid_i), .s_ready_o(s_ready_o),
        .pea_ready_i(pea_ready_i), .op_o(op_o), .op_valid_o(op_valid_o),
        .count_o(count_o), .busy_o(busy_o), .done_o(done_o), .state_o(dbg_state)
    );

    wire [VW-1:0] obs_vec = {s_ready_o, op_valid_o, busy_o, done_o, count_o, op_o};

    // Reference model: the buffer is a queue, a transfer is "busy until len words
    // were taken and the queue has run dry".
    logic [N_BITS-1:0] exp_q[$];
    bit m_busy = 0;
    bit m_done = 0;
    int m_acc  = 0;
    int m_len  = 0;

    function automatic bit m_ready();
        return m_busy && (m_acc < m_len) && (exp_q.size() < DEPTH);
    endfunction

    function automatic logic [VW-1:0] exp_vec();
        int sz = exp_q.size();
        logic [N_BITS-1:0] head = (sz > 0) ? exp_q[0] : '0;
        return {m_ready(), sz > 0, m_busy, m_done, PW'(sz), head};
    endfunction

    task automatic tick();
        int sz = exp_q.size();
        bit push = s_valid_i && m_ready();
        bit pop  = pea_ready_i && (sz > 0);
        if (rst_i) begin
            exp_q.delete(); m_busy = 0; m_acc = 0; m_done = 0;
        end else if (flush_i) begin
            exp_q.delete(); m_busy = 0; m_acc = 0; m_done = 0;
        end else begin
            m_done = 0;
            if (!m_busy) begin
                if (start_i) begin
                    if (len_i == 0) m_done = 1;
                    else begin m_busy = 1; m_len = int'(len_i); m_acc = 0; end
                end
            end else if (m_acc == m_len && (sz == 0 || (pop && sz == 1))) begin
                m_busy = 0; m_done = 1;
            end
            if (pop) void'(exp_q.pop_front());
            if (push) begin exp_q.push_back(s_data_i); m_acc++; end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        start_i = 0; flush_i = 0; s_valid_i = 0; pea_ready_i = 0; len_i = '0;
    endtask

    task automatic test_reset();
        rst_i = 1; start_i = 1; len_i = 16'd5;
        tick(); tick();
        n_vec++;
        if (obs_vec !== '0) begin n_err++; $display("FAIL reset_outputs: got %h want 0", obs_vec); end
        rst_i = 0; start_i = 0;
        tick();
        n_vec++;
        if (busy_o !== 1'b0 || obs_vec !== exp_vec()) begin
            n_err++; $display("FAIL reset_start_ignored: got %h want %h", obs_vec, exp_vec());
        end
    endtask

    task automatic test_basic();
        logic [N_BITS-1:0] vals [3];
        int dones = 0;
        vals[0] = 32'hA; vals[1] = 32'hB; vals[2] = 32'hC;
        start_i = 1; len_i = 16'd3; tick(); start_i = 0;
        s_valid_i = 1; pea_ready_i = 1;
        for (int c = 0; c < 10; c++) begin
            s_data_i = (m_acc < 3) ? vals[m_acc] : $urandom;
            n_vec++;
            if (obs_vec !== exp_vec()) begin
                n_err++; $display("FAIL basic cyc %0d: got %h want %h", c, obs_vec, exp_vec());
            end
            if (done_o) dones++;
            tick();
        end
        idle_inputs();
        n_vec++;
        if (dones !== 1 || busy_o !== 1'b0) begin
            n_err++; $display("FAIL basic_done: dones %0d busy %b want 1 and 0", dones, busy_o);
        end
    endtask

    task automatic test_full();
        start_i = 1; len_i = 16'd6; tick(); start_i = 0;
        s_valid_i = 1; pea_ready_i = 0;
        for (int c = 0; c < 6; c++) begin
            s_data_i = $urandom;
            n_vec++;
            if (obs_vec !== exp_vec()) begin
                n_err++; $display("FAIL full_fill cyc %0d: got %h want %h", c, obs_vec, exp_vec());
            end
            tick();
        end
        n_vec++;
        if (count_o !== PW'(4) || s_ready_o !== 1'b0) begin
            n_err++; $display("FAIL full_state: count %0d ready %b want 4 and 0", count_o, s_ready_o);
        end
        pea_ready_i = 1; s_data_i = $urandom; tick();
        n_vec++;
        if (count_o !== PW'(3) || s_ready_o !== 1'b1 || obs_vec !== exp_vec()) begin
            n_err++; $display("FAIL full_pop_no_push: got %h want %h (count 3)", obs_vec, exp_vec());
        end
        pea_ready_i = 0; s_data_i = $urandom; tick();
        n_vec++;
        if (count_o !== PW'(4) || obs_vec !== exp_vec()) begin
            n_err++; $display("FAIL full_resume: got %h want %h (count 4)", obs_vec, exp_vec());
        end
        pea_ready_i = 1;
        for (int c = 0; c < 12; c++) begin
            s_data_i = $urandom;
            n_vec++;
            if (obs_vec !== exp_vec()) begin
                n_err++; $display("FAIL full_drain cyc %0d: got %h want %h", c, obs_vec, exp_vec());
            end
            tick();
        end
        idle_inputs();
        n_vec++;
        if (busy_o !== 1'b0 || count_o !== '0) begin
            n_err++; $display("FAIL full_end: busy %b count %0d want 0 and 0", busy_o, count_o);
        end
    endtask

    task automatic test_zero_len();
        start_i = 1; len_i = '0; tick(); start_i = 0;
        n_vec++;
        if (done_o !== 1'b1 || busy_o !== 1'b0 || s_ready_o !== 1'b0) begin
            n_err++; $display("FAIL zero_len_done: done %b busy %b ready %b want 1 0 0", done_o, busy_o, s_ready_o);
        end
        tick();
        n_vec++;
        if (done_o !== 1'b0 || obs_vec !== exp_vec()) begin
            n_err++; $display("FAIL zero_len_after: got %h want %h", obs_vec, exp_vec());
        end
    endtask

    task automatic test_flush();
        start_i = 1; len_i = 16'd8; tick(); start_i = 0;
        s_valid_i = 1; pea_ready_i = 0;
        for (int c = 0; c < 3; c++) begin s_data_i = $urandom; tick(); end
        n_vec++;
        if (count_o !== PW'(3)) begin n_err++; $display("FAIL flush_pre: count %0d want 3", count_o); end
        flush_i = 1; pea_ready_i = 1; s_data_i = $urandom; tick();
        idle_inputs();
        n_vec++;
        if (count_o !== '0 || op_valid_o !== 1'b0 || busy_o !== 1'b0 || done_o !== 1'b0) begin
            n_err++; $display("FAIL flush_clear: got %h want count 0 valid 0 busy 0 done 0", obs_vec);
        end
        start_i = 1; len_i = 16'd2; tick(); start_i = 0;
        n_vec++;
        if (busy_o !== 1'b1 || obs_vec !== exp_vec()) begin
            n_err++; $display("FAIL flush_restart: got %h want %h", obs_vec, exp_vec());
        end
        s_valid_i = 1; pea_ready_i = 1;
        for (int c = 0; c < 8; c++) begin
            s_data_i = $urandom;
            n_vec++;
            if (obs_vec !== exp_vec()) begin
                n_err++; $display("FAIL flush_next cyc %0d: got %h want %h", c, obs_vec, exp_vec());
            end
            tick();
        end
        idle_inputs();
    endtask

    task automatic test_wrap();
        logic [N_BITS-1:0] sent_q[$];
        logic [N_BITS-1:0] got_q[$];
        int dones = 0;
        int c = 0;
        start_i = 1; len_i = 16'd20; tick(); start_i = 0;
        while (dones == 0 && c < 600) begin
            s_valid_i   = 1'($urandom_range(0, 1));
            pea_ready_i = 1'($urandom_range(0, 1));
            s_data_i    = $urandom;
            if (s_valid_i && m_ready()) sent_q.push_back(s_data_i);
            if (op_valid_o && pea_ready_i) got_q.push_back(op_o);
            n_vec++;
            if (obs_vec !== exp_vec() || count_o > PW'(4)) begin
                n_err++; $display("FAIL wrap cyc %0d: got %h want %h", c, obs_vec, exp_vec());
            end
            if (done_o) dones++;
            tick();
            c++;
        end
        idle_inputs();
        for (int k = 0; k < 4; k++) begin
            if (done_o) dones++;
            tick();
        end
        n_vec++;
        if (dones !== 1 || got_q.size() !== 20 || sent_q.size() !== 20) begin
            n_err++; $display("FAIL wrap_totals: dones %0d got %0d sent %0d want 1 20 20", dones, got_q.size(), sent_q.size());
        end else begin
            for (int k = 0; k < 20; k++) begin
                n_vec++;
                if (got_q[k] !== sent_q[k]) begin
                    n_err++; $display("FAIL wrap_order word %0d: got %h want %h", k, got_q[k], sent_q[k]);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        start_i = 1; len_i = 16'd6; tick(); start_i = 0;
        s_valid_i = 1; pea_ready_i = 0;
        for (int c = 0; c < 2; c++) begin s_data_i = $urandom; tick(); end
        n_vec++;
        if (count_o !== PW'(2) || busy_o !== 1'b1) begin
            n_err++; $display("FAIL rst_mid_pre: count %0d busy %b want 2 and 1", count_o, busy_o);
        end
        rst_i = 1; start_i = 1; len_i = 16'd3; tick();
        n_vec++;
        if (obs_vec !== '0) begin n_err++; $display("FAIL rst_mid_outputs: got %h want 0", obs_vec); end
        rst_i = 0; idle_inputs(); tick();
        n_vec++;
        if (busy_o !== 1'b0 || obs_vec !== exp_vec()) begin
            n_err++; $display("FAIL rst_mid_after: got %h want %h", obs_vec, exp_vec());
        end
    endtask

    initial begin
        #1;
        test_reset();
        test_basic();
        test_full();
        test_zero_len();
        test_flush();
        test_wrap();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule

// File: doc/s_stream_in_fifo.md
# s_stream_in_fifo

Streaming input buffer that sits directly upstream of a streaming PE operand port in the Mage PEA. It accepts a programmed number of words from the stream source over a valid/ready handshake and buffers them in a small FIFO. It presents them as an operand/valid pair to the PE's neighbour-operand input, and pops only when the array advances (`pea_ready_i`). A per-transfer FSM tracks the accepted word count, drains the FIFO, and reports completion.

## Interface
- `N_BITS`, 32, data width; matches the PE operand width.
- `DEPTH`, 4, FIFO entries; power of two, ≥2.
- `CNT_W`, 16, width of the transfer-length counter.
- `clk_i`  in  1  clock.
- `rst_i`  in  1  reset, synchronous, active-high.
- `start_i`  in  1  start-transfer pulse; sampled only in IDLE.
- `len_i`  in  CNT_W  number of words to accept; sampled with `start_i`.
- `flush_i`  in  1  synchronous abort: empties the FIFO and returns to IDLE without `done_o`.
- `s_data_i`  in  N_BITS  stream data from the source.
- `s_valid_i`  in  1  stream data valid.
- `s_ready_o`  out  1  buffer can accept a word.
- `pea_ready_i`  in  1  array advance; the PE consumes the head when this is high and `op_valid_o` is high.
- `op_o`  out  N_BITS  FIFO head, driven to the PE operand input.
- `op_valid_o`  out  1  head valid, driven to the PE operand-valid input.
- `count_o`  out  $clog2(DEPTH)+1  FIFO occupancy, 0..DEPTH.
- `busy_o`  out  1  FSM not in IDLE.
- `done_o`  out  1  single-cycle completion pulse.

## Operation
- Storage:
  - DEPTH-entry register array with write and read pointers of $clog2(DEPTH)+1 bits each.
  - The MSB distinguishes full from empty.
  - Pointers wrap modulo 2·DEPTH.
- Push: `s_valid_i && s_ready_o`.
  - `s_ready_o = (state==RUN) && !full && (acc_cnt != len_q)`.
  - `acc_cnt` increments on each push.
- Pop: `op_valid_o && pea_ready_i`.
  - `op_valid_o = !empty`.
  - `op_o = mem[rd_ptr]`; it is `'0` when empty.
- No bypass: a word pushed into an empty FIFO is visible the next cycle.
- Full FIFO with a simultaneous pop:
  - `s_ready_o` stays low; full has priority and there is no push-through.
  - Occupancy drops by 1.
- Simultaneous push and pop when not full or empty: occupancy unchanged, both pointers advance.
- FSM states: IDLE, RUN, DRAIN.
  - IDLE + `start_i`, `len_i`==0: stay in IDLE, set the `done_o` pulse for the next cycle.
  - IDLE + `start_i`, `len_i`>0: latch `len_q`, clear `acc_cnt`, go to RUN.
  - RUN: when a push makes `acc_cnt == len_q`, go to DRAIN.
  - DRAIN: when empty, or when the pop in this cycle empties the FIFO, go to IDLE and pulse `done_o` on the following cycle.
  - `start_i` outside IDLE is ignored.
- Pops are allowed in every state, including IDLE, so leftover data after a flush-free stop is still delivered.
- `flush_i`, any state:
  - Both pointers go to 0, `acc_cnt` goes to 0, state goes to IDLE, and no `done_o`.
  - It has priority over push, pop and `start_i` in the same cycle.
- `rst_i` has priority over everything. Mid-transfer reset discards all data with no `done_o`.
- Reset values: `s_ready_o`=0, `op_o`=0, `op_valid_o`=0, `count_o`=0, `busy_o`=0, `done_o`=0, all memory entries 0.

## Timing
- Input to PE latency: 1 cycle. Push at edge t gives `op_valid_o`=1 in cycle t+1.
- Throughput: 1 word/cycle sustained when not full and `pea_ready_i`=1.
- `count_o`, `busy_o` and `s_ready_o` update on the edge after the causing event. `s_ready_o` is combinational from registered state only.
- `s_ready_o` does not depend on `s_valid_i` or `pea_ready_i` (no combinational loop).
- `done_o` is registered: high exactly 1 cycle, in the first IDLE cycle after the DRAIN exit (or after `start_i` with `len_i`=0).
- `op_o` and `op_valid_o` are held stable while `pea_ready_i`=0.

## Test plan
- Basic transfer:
  - Stimulus: `len_i`=3, `s_valid_i` constant high with data 0xA,0xB,0xC; `pea_ready_i`=1.
  - Response: `op_o` shows 0xA,0xB,0xC on consecutive cycles starting 1 cycle after the first push.
  - Response: `s_ready_o` drops after the 3rd push.
  - Response: `done_o` pulses once, then `busy_o`=0.
- Backpressure and full:
  - Stimulus: `len_i`=6, `pea_ready_i`=0.
  - Response: 4 pushes, then `count_o`=4 and `s_ready_o`=0.
  - Stimulus: raise `pea_ready_i` for 1 cycle with `s_valid_i`=1.
  - Response: one pop, no push in that cycle, `count_o`=3.
  - Response: the push resumes next cycle; order is preserved.
- Zero length:
  - Stimulus: `start_i` with `len_i`=0.
  - Response: `s_ready_o` stays 0, `done_o`=1 the next cycle, `busy_o` stays 0.
- Flush mid-transfer:
  - Stimulus: `len_i`=8; after 3 pushes and 0 pops, assert `flush_i`.
  - Response: next cycle `count_o`=0, `op_valid_o`=0, `busy_o`=0, no `done_o`.
  - Response: a new `start_i` is accepted the following cycle.
- Pointer wrap-around:
  - Stimulus: `len_i`=20 with random `s_valid_i` and `pea_ready_i` (50% each).
  - Response: all 20 words arrive in order, `count_o` never exceeds 4, and `done_o` pulses once.
- Reset mid-operation:
  - Stimulus: assert `rst_i` with `count_o`=2 in RUN.
  - Response: next cycle all outputs are at their reset values.
  - Response: `start_i` during `rst_i` is ignored.
